// File: rtl/solve_log.sv
// Records the solver's chosen move per step while a solve runs, then replays
// the recorded sequence in order over a valid/ready stream once it ends.
module solve_log #(
    parameter int MAX_STEPS = 10,
    parameter int SW        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [3:0]    addr,
    input  logic [SW-1:0] step,
    input  logic          fin,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [SW-1:0] out_data,
    output logic [3:0]    out_index,
    output logic          out_last,
    output logic [3:0]    count,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [1:0]    dbg_state
);

    // Stream handshake: a move transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid/out_data/out_index/out_last are
    // registers that hold until that transfer, and out_valid never depends
    // combinationally on out_ready.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(MAX_STEPS);

    state_t                         state;
    logic [MAX_STEPS-1:0][SW-1:0]   slots;
    logic [3:0]                     rp;
    logic                           hit_limit;
    logic                           flush_on_fin;

    logic                           wr_en;
    logic [3:0]                     wr_idx;
    logic [3:0]                     count_wr;
    logic [3:0]                     rp_nxt;

    assign wr_en     = (addr != 4'd0) && (addr <= LIMIT);
    assign wr_idx    = addr - 4'd1;
    assign count_wr  = (wr_en && (addr > count)) ? addr : count;
    assign rp_nxt    = rp + 4'd1;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            slots        <= '0;
            rp           <= 4'd0;
            hit_limit    <= 1'b0;
            flush_on_fin <= 1'b0;
            count        <= 4'd0;
            done         <= 1'b0;
            fail         <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_index    <= 4'd0;
            out_last     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        slots     <= '0;
                        count     <= 4'd0;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        hit_limit <= 1'b0;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (wr_en) begin
                        slots[wr_idx] <= step;
                        count         <= count_wr;
                        if (addr == LIMIT) hit_limit <= 1'b1;
                    end
                    // fin wins over the limit; the limit only counts once the
                    // last slot has already been written in an earlier cycle
                    if (fin) begin
                        flush_on_fin <= 1'b1;
                        state        <= FLUSH;
                    end else if ((addr == LIMIT) && hit_limit) begin
                        fail         <= 1'b1;
                        flush_on_fin <= 1'b0;
                        state        <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (wr_en) begin
                        slots[wr_idx] <= step;
                        count         <= count_wr;
                    end
                    if (flush_on_fin) done <= 1'b1;
                    rp    <= 4'd0;
                    state <= (count_wr != 4'd0) ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= slots[rp];
                        out_index <= rp;
                        out_last  <= (rp == count - 4'd1);
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            rp        <= rp_nxt;
                            out_data  <= slots[rp_nxt];
                            out_index <= rp_nxt;
                            out_last  <= (rp_nxt == count - 4'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) &&
                                       $stable(out_index) && $stable(out_last)));

endmodule

// File: tb/tb_solve_log.sv
// Directed bench for solve_log: a list-level model of the capture rules
// predicts the drained stream and the final flags for each solve.
module tb_solve_log;

    localparam int MAX = 10;
    localparam int SW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [3:0]    addr;
    logic [SW-1:0] step;
    logic          fin;
    logic          out_ready;
    logic          out_valid;
    logic [SW-1:0] out_data;
    logic [3:0]    out_index;
    logic          out_last;
    logic [3:0]    count;
    logic          busy;
    logic          done;
    logic          fail;
    logic [1:0]    dbg_state;

    solve_log #(.MAX_STEPS(MAX), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .addr(addr), .step(step), .fin(fin),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .count(count), .busy(busy),
        .done(done), .fail(fail), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // scoreboard entries are {last, index, data}
    logic [8:0] exp_q[$];
    int         exp_len;
    int         exp_count;
    bit         exp_done;
    bit         exp_fail;
    int         xfer_cnt;

    int s_a[$];
    int s_s[$];
    int s_f[$];
    int s_r[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_samples();
        s_a.delete(); s_s.delete(); s_f.delete(); s_r.delete();
    endtask

    task automatic add(input int a, input int s, input int f, input int r = 0);
        s_a.push_back(a); s_s.push_back(s); s_f.push_back(f); s_r.push_back(r);
    endtask

    task automatic add_normal();
        clear_samples();
        add(1, 5, 0); add(2, 2, 0); add(3, 2, 1); add(3, 7, 0);
    endtask

    task automatic add_stale();
        clear_samples();
        add(0, 0, 0); add(2, 4, 0); add(3, 6, 1); add(3, 6, 0);
    endtask

    // Walk the per-cycle solver samples through the capture/flush rules.
    task automatic build_model();
        logic [SW-1:0] sl [MAX];
        logic [8:0]    e;
        int            cnt;
        int            phase;
        int            a;
        bit            seen;
        bit            onf;
        for (int k = 0; k < MAX; k++) sl[k] = '0;
        cnt = 0; phase = 0; seen = 0; onf = 0;
        exp_done = 0; exp_fail = 0;
        for (int i = 0; i < s_a.size() && phase < 2; i++) begin
            a = s_a[i];
            if (phase == 0) begin
                if (s_f[i] != 0) begin
                    onf = 1; phase = 1;
                end else if (a == MAX && seen) begin
                    exp_fail = 1; phase = 1;
                end
                if (a >= 1 && a <= MAX) begin
                    sl[a-1] = SW'(s_s[i]);
                    if (a > cnt) cnt = a;
                    if (a == MAX) seen = 1;
                end
            end else begin
                if (a >= 1 && a <= MAX) begin
                    sl[a-1] = SW'(s_s[i]);
                    if (a > cnt) cnt = a;
                end
                exp_done = onf;
                phase = 2;
            end
        end
        exp_count = cnt;
        exp_q.delete();
        for (int k = 0; k < cnt; k++) begin
            e = {(k == cnt - 1), 4'(k), sl[k]};
            exp_q.push_back(e);
        end
        exp_len = cnt;
        xfer_cnt = 0;
    endtask

    // driver: pulse run, then replay the solver samples one per cycle
    task automatic capture(input bit zero_chk);
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        chk("enter_busy", busy, 1);
        for (int i = 0; i < s_a.size(); i++) begin
            addr = 4'(s_a[i]); step = SW'(s_s[i]); fin = s_f[i][0]; run = s_r[i][0];
            @(posedge clk); #1;
            if (zero_chk) chk("zero_busy", busy, (i == 0) ? 1 : 0);
        end
        addr = 4'd0; step = '0; fin = 1'b0; run = 1'b0;
    endtask

    task automatic drain(input int mode, input bit run_in_drain);
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        for (int k = 0; k < 200; k++) begin
            out_ready = (mode == 1) ? pat[k % 6][0] : 1'b1;
            if (run_in_drain) begin
                run = (k < 3);
                out_ready = (k >= 4);
            end
            @(posedge clk); #1;
            if (!busy) break;
        end
        run = 1'b0;
        out_ready = 1'b1;
        chk("drain_timeout", busy, 0);
    endtask

    task automatic final_checks();
        chk("done", done, exp_done);
        chk("fail", fail, exp_fail);
        chk("count", count, exp_count);
        chk("left_in_queue", exp_q.size(), 0);
        chk("xfers", xfer_cnt, exp_len);
        chk("idle_valid", out_valid, 0);
    endtask

    task automatic reset_checks();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_last", out_last, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
    endtask

    // scoreboard / compare process
    bit         prev_v = 0;
    bit         prev_r = 0;
    logic [8:0] prev_o = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {out_last, out_index, out_data}, prev_o);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    chk("stream", {out_last, out_index, out_data}, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_o = {out_last, out_index, out_data};
        end
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; addr = 4'd0; step = '0; fin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        rst_n = 1'b1;

        // normal solve: step for addr 3 arrives one cycle after fin
        add_normal();
        build_model();
        chk("pin_norm_len", exp_len, 3);
        chk("pin_norm_first", exp_q[0], 9'b0_0000_0101);
        chk("pin_norm_last", exp_q[2], 9'b1_0010_0111);
        capture(0);
        drain(0, 0);
        final_checks();
        chk("norm_done_lit", done, 1);
        chk("norm_count_lit", count, 3);

        // step-limit fail
        clear_samples();
        for (int k = 1; k <= MAX; k++) add(k, k, 0);
        add(MAX, MAX, 0); add(MAX, MAX, 0);
        build_model();
        chk("pin_fail_flag", exp_fail, 1);
        chk("pin_fail_last", exp_q[9], 9'b1_1001_1010);
        capture(0);
        drain(0, 0);
        final_checks();
        chk("fail_lit", fail, 1);
        chk("fail_count_lit", count, 10);

        // new run after a full buffer: unwritten slot 0 must read 0
        add_stale();
        build_model();
        chk("pin_stale_first", exp_q[0], 9'b0_0000_0000);
        capture(0);
        drain(0, 0);
        final_checks();

        // backpressure
        add_normal();
        build_model();
        capture(0);
        drain(1, 0);
        final_checks();
        chk("bp_xfers_lit", xfer_cnt, 3);

        // zero-move solve
        clear_samples();
        add(0, 0, 1); add(0, 0, 0);
        build_model();
        capture(1);
        drain(0, 0);
        final_checks();
        chk("zero_done_lit", done, 1);
        chk("zero_count_lit", count, 0);

        // run during CAPTURE and during DRAIN
        clear_samples();
        add(1, 3, 0); add(2, 8, 0, 1); add(2, 8, 1); add(2, 8, 0);
        build_model();
        capture(0);
        drain(0, 1);
        final_checks();
        chk("ign_count_lit", count, 2);

        // fin together with the step limit
        clear_samples();
        for (int k = 1; k <= MAX; k++) add(k, k, 0);
        add(MAX, 5, 1); add(MAX, 5, 0);
        build_model();
        capture(0);
        drain(0, 0);
        final_checks();
        chk("sim_done_lit", done, 1);
        chk("sim_fail_lit", fail, 0);

        // reset mid-DRAIN, then restart
        add_normal();
        build_model();
        out_ready = 1'b0;
        capture(0);
        for (int k = 0; k < 10 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        reset_checks();
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        add_stale();
        build_model();
        capture(0);
        drain(0, 0);
        final_checks();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
